// File: rtl/bcd2bin_conv.sv
// bcd2bin_conv: sequential BCD-to-binary converter (reverse double-dabble: shift right, subtract 3)
module bcd2bin_conv #(
  parameter int DIGITS = 16,
  parameter int BIN_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  init,
  output logic                  ready,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err_digit,
  output logic                  overflow
);
  localparam int CW = $clog2(BIN_W) + 1;
  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, ADJUST, DONE} state_t;
  state_t state, state_n;
  logic [4*DIGITS-1:0] bcd, bcd_n, bcd_adj;
  logic [BIN_W-1:0] bin, bin_n, bin_out_n;
  logic [CW-1:0] count, count_n;
  logic ready_n, done_n, err_n, ovf_n, bad;
  always_comb begin
    bad = 1'b0;
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (bcd[4*i+:4] > 4'd9);
      bcd_adj[4*i+:4] = (bcd[4*i+:4] >= 4'd8) ? bcd[4*i+:4] - 4'd3 : bcd[4*i+:4];
    end
  end
  always_comb begin
    state_n = state;
    bcd_n = bcd;
    bin_n = bin;
    count_n = count;
    bin_out_n = bin_out;
    ready_n = ready;
    done_n = 1'b0;
    err_n = err_digit;
    ovf_n = overflow;
    case (state)
      IDLE: if (init) begin
        bcd_n = bcd_in;
        bin_n = '0;
        count_n = CW'(BIN_W);
        ready_n = 1'b0;
        err_n = 1'b0;
        ovf_n = 1'b0;
        state_n = CHECK;
      end
      CHECK: begin
        err_n = bad;
        bin_n = bad ? '0 : bin;
        state_n = bad ? DONE : SHIFT;
      end
      SHIFT: begin
        bin_n = {bcd[0], bin[BIN_W-1:1]};
        bcd_n = {1'b0, bcd[4*DIGITS-1:1]};
        count_n = count - 1'b1;
        state_n = ADJUST;
      end
      ADJUST: begin
        bcd_n = bcd_adj;
        state_n = (count == '0) ? DONE : SHIFT;
      end
      DONE: begin
        bin_out_n = bin;
        // leftover BCD after all shifts is the quotient by 2**BIN_W
        ovf_n = ~err_digit & (|bcd);
        done_n = 1'b1;
        ready_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bcd <= '0;
      bin <= '0;
      count <= '0;
      bin_out <= '0;
      ready <= 1'b1;
      done <= 1'b0;
      err_digit <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      bcd <= bcd_n;
      bin <= bin_n;
      count <= count_n;
      bin_out <= bin_out_n;
      ready <= ready_n;
      done <= done_n;
      err_digit <= err_n;
      overflow <= ovf_n;
    end
  end
endmodule

// File: tb/tb_bcd2bin_conv.sv
// tb_bcd2bin_conv: scoreboard bench with an arithmetic reference model for bcd2bin_conv
module tb_bcd2bin_conv;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] bcd_in = '0;
  logic init = 1'b0;
  logic ready, done, err_digit, overflow;
  logic [31:0] bin_out;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [31:0] bin;
    logic ovf;
    logic err;
    int at;
  } exp_t;
  exp_t q[$];

  bcd2bin_conv dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .init(init), .ready(ready),
    .done(done), .bin_out(bin_out), .err_digit(err_digit), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // value from decimal digit weights; result is its low 32 bits
  function automatic exp_t model(input logic [63:0] b, input int acc);
    exp_t e;
    logic [63:0] v = '0;
    logic [3:0] d;
    e.err = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      d = b[4*i+:4];
      if (d > 4'd9) e.err = 1'b1;
      v = v * 64'd10 + 64'(d);
    end
    e.bin = e.err ? 32'd0 : v[31:0];
    e.ovf = !e.err && (v >= 64'h1_0000_0000);
    e.at = acc + (e.err ? 2 : 66);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bin_out", 64'(bin_out), 64'(e.bin));
        chk("overflow", 64'(overflow), 64'(e.ovf));
        chk("err_digit", 64'(err_digit), 64'(e.err));
        chk("ready_with_done", 64'(ready), 64'd1);
        chk("latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", 64'(ready), 64'd1);
  endtask

  task automatic issue(input logic [63:0] b);
    wait_ready();
    bcd_in = b;
    init = 1'b1;
    q.push_back(model(b, cyc + 1));
    @(negedge clk);
    init = 1'b0;
    bcd_in = {$urandom, $urandom};
  endtask

  function automatic logic [63:0] rand_bcd();
    logic [63:0] b = '0;
    int nd = $urandom_range(1, 16);
    for (int i = 0; i < nd; i++) b[4*i+:4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 5) == 0) b[4*$urandom_range(0, 15)+:4] = 4'($urandom_range(10, 15));
    return b;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bin", 64'(bin_out), 64'd0);
    chk("rst_err", 64'(err_digit), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    issue(64'h0);
    issue(64'h12345678);
    issue(64'h4294967295);
    issue(64'h4294967296);
    issue(64'h9999999999999999);
    issue(64'h000000000000001A);
    issue(64'h1000000000000000);
    for (int n = 0; n < 30; n++) issue(rand_bcd());
    begin
      int t = 0;
      wait_ready();
      bcd_in = 64'h87654321;
      init = 1'b1;
      q.push_back(model(64'h87654321, cyc + 1));
      do begin
        @(negedge clk);
        t++;
      end while (!done && t < 100);
      chk("b2b_first_done", 64'(done), 64'd1);
      bcd_in = 64'h00000000000000F0;
      q.push_back(model(64'h00000000000000F0, cyc + 1));
      @(negedge clk);
      init = 1'b0;
    end
    issue(64'h0000000000000999);
    repeat (9) @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_bin", 64'(bin_out), 64'd0);
    chk("abort_flags", 64'({err_digit, overflow}), 64'd0);
    repeat (80) @(negedge clk);
    issue(64'h4294967295);
    begin
      int t = 0;
      while (q.size() != 0 && t < 300) begin
        @(negedge clk);
        t++;
      end
      chk("drain", 64'(q.size()), 64'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
